// File: rtl/ifetch_reader_pkg.sv
// Shared types and constants for the fetch-stage instruction reader.
package ifetch_reader_pkg;

  typedef enum logic [2:0] {
    S_REQ0  = 3'd0,
    S_WAIT0 = 3'd1,
    S_REQ1  = 3'd2,
    S_WAIT1 = 3'd3,
    S_HOLD  = 3'd4,
    S_DRAIN = 3'd5
  } fetch_state_e;

  localparam int          LONG_BIT_DEF = 15;
  localparam logic [31:0] PC_RESET_VEC = 32'h20;
  localparam logic [31:0] PC_INTR_VEC  = 32'h0;
  localparam logic [1:0]  INCR_SHORT   = 2'd1;
  localparam logic [1:0]  INCR_LONG    = 2'd2;

  function automatic logic [1:0] incr_for(input logic is_long);
    return is_long ? INCR_LONG : INCR_SHORT;
  endfunction

endpackage

// File: rtl/ifetch_reader_if.sv
// Memory request/response and decode-side handshake bundle for ifetch_reader.
interface ifetch_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0]   out_pc;

  modport master (
    output mem_req_valid, mem_addr, out_valid, out_instr, out_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_addr, out_valid, out_instr, out_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready
  );
endinterface

// File: rtl/ifetch_reader.sv
// Fetch-stage reader: reads 1- or 2-word instructions at pc_i and hands them to decode.
// Optional FETCH_BYPASS_EN forwards the final memory word to decode in its arrival cycle.
module ifetch_reader
  import ifetch_reader_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16,
  parameter int LONG_BIT = LONG_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  ifetch_reader_if.master   bus,
  output logic              pc_adv,
  output logic [1:0]        pc_incr
);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] word0_q, word1_q;
  logic [ADDR_W-1:0] out_pc_q;

  logic         rsp, req_fire, is_long;
  fetch_state_e done_st;

  assign rsp      = bus.mem_rsp_valid;
  assign req_fire = bus.mem_req_valid & bus.mem_req_ready;

  always_comb begin
    bus.mem_req_valid = !rst && (state_q == S_REQ0 || state_q == S_REQ1);
    bus.mem_addr      = (state_q == S_REQ1) ? out_pc_q + ADDR_W'(1) : pc_i;
    bus.out_pc        = out_pc_q;
`ifdef FETCH_BYPASS_EN
    // Last word of the instruction can go straight to decode in its arrival cycle.
    bus.out_valid = !rst && !flush_i && ((state_q == S_HOLD) ||
                    (state_q == S_WAIT0 && rsp && !bus.mem_rsp_data[LONG_BIT]) ||
                    (state_q == S_WAIT1 && rsp));
    if (state_q == S_WAIT0 && rsp) begin
      bus.out_instr = {bus.mem_rsp_data, {DATA_W{1'b0}}};
      is_long       = 1'b0;
    end else if (state_q == S_WAIT1 && rsp) begin
      bus.out_instr = {word0_q, bus.mem_rsp_data};
      is_long       = 1'b1;
    end else begin
      bus.out_instr = {word0_q, word1_q};
      is_long       = word0_q[LONG_BIT];
    end
    done_st = bus.out_ready ? S_REQ0 : S_HOLD;
`else
    bus.out_valid = !rst && !flush_i && (state_q == S_HOLD);
    bus.out_instr = {word0_q, word1_q};
    is_long       = word0_q[LONG_BIT];
    done_st       = S_HOLD;
`endif
    pc_adv  = bus.out_valid & bus.out_ready;
    pc_incr = pc_adv ? incr_for(is_long) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ0;
      word0_q  <= '0;
      word1_q  <= '0;
      out_pc_q <= '0;
    end else begin
      case (state_q)
        S_REQ0: begin
          if (flush_i)       state_q <= req_fire ? S_DRAIN : S_REQ0;
          else if (req_fire) begin
            state_q  <= S_WAIT0;
            out_pc_q <= pc_i;
          end
        end
        S_WAIT0: begin
          // A response landing with the flush is simply dropped: nothing left in flight.
          if (flush_i)  state_q <= rsp ? S_REQ0 : S_DRAIN;
          else if (rsp) begin
            word0_q <= bus.mem_rsp_data;
            if (bus.mem_rsp_data[LONG_BIT]) state_q <= S_REQ1;
            else begin
              word1_q <= '0;
              state_q <= done_st;
            end
          end
        end
        S_REQ1: begin
          if (flush_i)       state_q <= req_fire ? S_DRAIN : S_REQ0;
          else if (req_fire) state_q <= S_WAIT1;
        end
        S_WAIT1: begin
          if (flush_i)  state_q <= rsp ? S_REQ0 : S_DRAIN;
          else if (rsp) begin
            word1_q <= bus.mem_rsp_data;
            state_q <= done_st;
          end
        end
        S_HOLD:  if (flush_i || bus.out_ready) state_q <= S_REQ0;
        S_DRAIN: if (rsp) state_q <= S_REQ0;
        default: state_q <= S_REQ0;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_reader.sv
// Scoreboard bench for ifetch_reader: memory model with programmable latency plus PC register model.
module tb_ifetch_reader;
  import ifetch_reader_pkg::*;

  localparam int AW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [AW-1:0] pc = PC_RESET_VEC;
  logic          pc_adv;
  logic [1:0]    pc_incr;

  ifetch_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ifetch_reader #(.ADDR_W(AW), .DATA_W(DW), .LONG_BIT(LONG_BIT_DEF)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_i    (pc),
    .flush_i (flush),
    .bus     (bus.master),
    .pc_adv  (pc_adv),
    .pc_incr (pc_incr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  incr;
  } exp_t;

  exp_t          sb[$];
  logic [31:0]   req_log[$];
  logic [15:0]   mem [logic [31:0]];
  int            n_checks, n_pass, accepted, lat;
  bit            keep_inflight, saw_dead;

  // Memory: one outstanding read, response lat cycles after the accepting edge.
  task automatic mem_model();
    bit pend = 0;
    int cnt = 0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (rst && !keep_inflight) pend = 0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = mem.exists(paddr) ? mem[paddr] : 16'h0000;
          pend = 0;
        end
      end
      if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
        pend  = 1;
        cnt   = lat;
        paddr = bus.mem_addr;
        req_log.push_back(bus.mem_addr);
      end
    end
  endtask

  // Decode side: compares every accepted instruction and advances the PC.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus.out_valid && bus.out_instr[31:16] == 16'hDEAD) saw_dead = 1;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_accept instr=%h pc=%h", bus.out_instr, bus.out_pc);
          end else begin
            e = sb.pop_front();
            n_checks++;
            if (bus.out_instr !== e.instr) $display("FAIL out_instr got=%h exp=%h", bus.out_instr, e.instr);
            else n_pass++;
            n_checks++;
            if (bus.out_pc !== e.pc) $display("FAIL out_pc got=%h exp=%h", bus.out_pc, e.pc);
            else n_pass++;
            n_checks++;
            if (pc_adv !== 1'b1) $display("FAIL pc_adv got=%b exp=1", pc_adv);
            else n_pass++;
            n_checks++;
            if (pc_incr !== e.incr) $display("FAIL pc_incr got=%0d exp=%0d", pc_incr, e.incr);
            else n_pass++;
            pc = pc + 32'(e.incr);
          end
          accepted++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.mem_req_ready = 1'b1;
    sb.delete();
    req_log.delete();
    keep_inflight = 0;
    saw_dead = 0;
    accepted = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input string name);
    int t = 0;
    while (accepted < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_checks++;
    if (accepted < n) $display("FAIL %s_timeout accepted=%0d exp=%0d", name, accepted, n);
    else n_pass++;
  endtask

  task automatic wait_reqs(input int n, input string name);
    int t = 0;
    while (req_log.size() < n && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    n_checks++;
    if (req_log.size() < n) $display("FAIL %s_req_timeout reqs=%0d exp=%0d", name, req_log.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    mem.delete();
    mem[32'h20] = 16'h1234;
    lat = 1;
    pc = PC_RESET_VEC;
    do_reset();
    @(negedge clk);
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (pc_adv !== 1'b0) $display("FAIL rst_pc_adv got=%b exp=0", pc_adv); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rst_req_valid got=%b exp=0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.out_instr !== 32'h0) $display("FAIL rst_out_instr got=%h exp=0", bus.out_instr); else n_pass++;
    n_checks++; if (bus.out_pc !== 32'h0) $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc); else n_pass++;
    n_checks++; if (pc_incr !== 2'd0) $display("FAIL rst_pc_incr got=%0d exp=0", pc_incr); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #2;
    n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL first_req_valid got=%b exp=1", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h20) $display("FAIL first_req_addr got=%h exp=20", bus.mem_addr); else n_pass++;
  endtask

  task automatic test_short();
    int n = 0;
    int exp_n;
    mem[32'h20] = 16'h1234;
    lat = 2;
`ifdef FETCH_BYPASS_EN
    exp_n = 1 + lat;
`else
    exp_n = 2 + lat;
`endif
    pc = 32'h20;
    do_reset();
    sb.push_back('{32'h12340000, 32'h20, INCR_SHORT});
    bus.out_ready = 1'b1;
    rst = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      #2;
      n++;
      if (bus.out_valid) break;
    end
    n_checks++;
    if (n != exp_n) $display("FAIL short_latency got=%0d exp=%0d", n, exp_n);
    else n_pass++;
    wait_acc(1, "short");
    bus.out_ready = 1'b0;
  endtask

  task automatic test_long();
    logic [31:0] a1;
    mem[32'h20] = 16'h8001;
    mem[32'h21] = 16'hBEEF;
    lat = 1;
    pc = 32'h20;
    do_reset();
    sb.push_back('{32'h8001BEEF, 32'h20, INCR_LONG});
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_acc(1, "long");
    bus.out_ready = 1'b0;
    a1 = (req_log.size() > 1) ? req_log[1] : 32'hFFFF_FFFF;
    n_checks++;
    if (a1 !== 32'h21) $display("FAIL long_second_addr got=%h exp=21", a1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a3;
    mem[32'h20] = 16'h0101;
    mem[32'h21] = 16'h8002;
    mem[32'h22] = 16'h2222;
    mem[32'h23] = 16'h0303;
    lat = 1;
    pc = 32'h20;
    do_reset();
    sb.push_back('{32'h01010000, 32'h20, INCR_SHORT});
    sb.push_back('{32'h80022222, 32'h21, INCR_LONG});
    sb.push_back('{32'h03030000, 32'h23, INCR_SHORT});
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_acc(3, "b2b");
    bus.out_ready = 1'b0;
    a3 = (req_log.size() > 3) ? req_log[3] : 32'hFFFF_FFFF;
    n_checks++;
    if (a3 !== 32'h23) $display("FAIL b2b_fourth_addr got=%h exp=23", a3);
    else n_pass++;
  endtask

  task automatic test_flush_wait();
    logic [31:0] a1;
    mem[32'h40] = 16'hDEAD;
    mem[32'h00] = 16'h0042;
    lat = 3;
    pc = 32'h40;
    do_reset();
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_reqs(1, "flush");
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (pc_adv !== 1'b0) $display("FAIL flush_pc_adv got=%b exp=0", pc_adv); else n_pass++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc = PC_INTR_VEC;
    sb.push_back('{32'h00420000, 32'h0, INCR_SHORT});
    wait_acc(1, "flush");
    bus.out_ready = 1'b0;
    n_checks++;
    if (saw_dead !== 1'b0) $display("FAIL flush_stale_seen got=%b exp=0", saw_dead);
    else n_pass++;
    a1 = (req_log.size() > 1) ? req_log[1] : 32'hFFFF_FFFF;
    n_checks++;
    if (a1 !== 32'h0) $display("FAIL flush_next_addr got=%h exp=0", a1);
    else n_pass++;
  endtask

  task automatic test_flush_with_rsp();
    logic [31:0] a1;
    mem[32'h40] = 16'hDEAD;
    mem[32'h60] = 16'h0066;
    lat = 1;
    pc = 32'h40;
    do_reset();
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_reqs(1, "flush_rsp");
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc = 32'h60;
    sb.push_back('{32'h00660000, 32'h60, INCR_SHORT});
    @(negedge clk);
    #2;
    a1 = (req_log.size() == 2) ? req_log[1] : 32'hFFFF_FFFF;
    n_checks++;
    if (a1 !== 32'h60) $display("FAIL flush_rsp_immediate_req got=%h exp=60", a1);
    else n_pass++;
    wait_acc(1, "flush_rsp");
    bus.out_ready = 1'b0;
    n_checks++;
    if (saw_dead !== 1'b0) $display("FAIL flush_rsp_stale_seen got=%b exp=0", saw_dead);
    else n_pass++;
  endtask

  task automatic test_stall();
    int t = 0;
    mem[32'h20] = 16'h0777;
    mem[32'h50] = 16'h0555;
    lat = 1;
    pc = 32'h20;
    do_reset();
    rst = 1'b0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.out_instr !== 32'h07770000) $display("FAIL stall_instr c%0d got=%h exp=07770000", i, bus.out_instr); else n_pass++;
      n_checks++; if (bus.out_pc !== 32'h20) $display("FAIL stall_pc c%0d got=%h exp=20", i, bus.out_pc); else n_pass++;
      n_checks++; if (pc_adv !== 1'b0) $display("FAIL stall_pc_adv c%0d got=%b exp=0", i, pc_adv); else n_pass++;
      n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL stall_req c%0d got=%b exp=0", i, bus.mem_req_valid); else n_pass++;
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL hold_flush_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (pc_adv !== 1'b0) $display("FAIL hold_flush_pc_adv got=%b exp=0", pc_adv); else n_pass++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc = 32'h50;
    sb.push_back('{32'h05550000, 32'h50, INCR_SHORT});
    wait_acc(1, "stall");
    bus.out_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    mem[32'h20] = 16'h8001;
    mem[32'h21] = 16'h1111;
    mem[32'h30] = 16'h0055;
    lat = 4;
    pc = 32'h20;
    do_reset();
    keep_inflight = 1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_reqs(2, "rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_req_ready = 1'b0;
    pc = 32'h30;
    @(negedge clk);
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (pc_adv !== 1'b0) $display("FAIL rst_mid_pc_adv got=%b exp=0", pc_adv); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    n_checks++; if (accepted !== 0) $display("FAIL rst_mid_late_rsp accepted=%0d exp=0", accepted); else n_pass++;
    n_checks++; if (bus.mem_addr !== 32'h30) $display("FAIL rst_mid_restart_addr got=%h exp=30", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL rst_mid_restart_req got=%b exp=1", bus.mem_req_valid); else n_pass++;
    sb.push_back('{32'h00550000, 32'h30, INCR_SHORT});
    @(posedge clk);
    #1;
    keep_inflight = 0;
    bus.mem_req_ready = 1'b1;
    wait_acc(1, "rst_mid");
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    accepted = 0;
    lat = 1;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    bus.out_ready = 1'b0;
    fork
      mem_model();
      monitor();
    join_none
    test_reset();
    test_short();
    test_long();
    test_back_to_back();
    test_flush_wait();
    test_flush_with_rsp();
    test_stall();
    test_rst_mid();
    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
